vector_sequencer: RTL

VECTOR_SEQUENCER -- requirements
Module: vector_sequencer

---
 rtl/vector_sequencer_if.sv | 34 +++
 rtl/vector_sequencer.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/vector_sequencer_if.sv
// Bus between vector_sequencer and its environment: start, vector memory
// read port, datapath stimulus/response and run results.
interface vector_sequencer_if #(
  parameter int IN_W  = 3,
  parameter int OUT_W = 1,
  parameter int DEPTH = 32
) ();
  localparam int AW = $clog2(DEPTH);

  logic                    i_start;
  logic [AW-1:0]           o_vec_addr;
  logic [IN_W+OUT_W:0]     i_vec_rdata;
  logic [IN_W-1:0]         o_dut_in;
  logic [OUT_W-1:0]        i_dut_out;
  logic                    o_busy;
  logic                    o_done;
  logic                    o_err_pulse;
  logic [15:0]             o_errors;
  logic [15:0]             o_vec_count;
  logic [AW-1:0]           o_first_fail;
  logic                    o_fail_seen;

  modport master (
    output i_start, i_vec_rdata, i_dut_out,
    input  o_vec_addr, o_dut_in, o_busy, o_done, o_err_pulse,
           o_errors, o_vec_count, o_first_fail, o_fail_seen
  );

  modport slave (
    input  i_start, i_vec_rdata, i_dut_out,
    output o_vec_addr, o_dut_in, o_busy, o_done, o_err_pulse,
           o_errors, o_vec_count, o_first_fail, o_fail_seen
  );
endinterface

// File: rtl/vector_sequencer.sv
// Steps through a vector memory, drives stimulus, waits SETTLE cycles and checks the response.
// Optional: define VECSEQ_STOP_ON_ERR_EN to end the run at the first mismatch.
module vector_sequencer #(
  parameter int IN_W   = 3,
  parameter int OUT_W  = 1,
  parameter int DEPTH  = 32,
  parameter int SETTLE = 2
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  vector_sequencer_if.slave  bus
);
  localparam int              AW        = $clog2(DEPTH);
  localparam logic [AW-1:0]   LAST_ADDR = AW'(DEPTH - 1);
  localparam logic [3:0]      SETTLE_LD = 4'(SETTLE);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_SETTLE,
    ST_CHECK,
    ST_DONE
  } state_e;

  state_e             r_state;
  state_e             w_next;

  logic [AW-1:0]      r_vec_addr;
  logic [IN_W-1:0]    r_dut_in;
  logic [OUT_W-1:0]   r_exp;
  logic [3:0]         r_cnt;
  logic [15:0]        r_errors;
  logic [15:0]        r_vec_count;
  logic [AW-1:0]      r_first_fail;
  logic               r_fail_seen;

  logic               w_valid;
  logic [IN_W-1:0]    w_vin;
  logic [OUT_W-1:0]   w_vexp;
  logic               w_mismatch;
  logic               w_stop;

  assign w_valid    = bus.i_vec_rdata[IN_W+OUT_W];
  assign w_vin      = bus.i_vec_rdata[IN_W+OUT_W-1:OUT_W];
  assign w_vexp     = bus.i_vec_rdata[OUT_W-1:0];
  assign w_mismatch = (bus.i_dut_out != r_exp);

`ifdef VECSEQ_STOP_ON_ERR_EN
  assign w_stop = w_mismatch;
`else
  assign w_stop = 1'b0;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= ST_IDLE;
    else          r_state <= w_next;
  end

  // SETTLE=0 goes straight from FETCH to CHECK, giving a 2-cycle vector
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE, ST_DONE: if (bus.i_start) w_next = ST_FETCH;
      ST_FETCH: begin
        if (!w_valid)          w_next = ST_DONE;
        else if (SETTLE == 0)  w_next = ST_CHECK;
        else                   w_next = ST_SETTLE;
      end
      ST_SETTLE: if (r_cnt <= 4'd1) w_next = ST_CHECK;
      ST_CHECK: begin
        if (w_stop || r_vec_addr == LAST_ADDR) w_next = ST_DONE;
        else                                   w_next = ST_FETCH;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.o_busy      = 1'b0;
    bus.o_done      = 1'b0;
    bus.o_err_pulse = 1'b0;
    unique case (r_state)
      ST_FETCH, ST_SETTLE: bus.o_busy = 1'b1;
      ST_CHECK: begin
        bus.o_busy      = 1'b1;
        bus.o_err_pulse = w_mismatch;
      end
      ST_DONE: bus.o_done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_vec_addr   <= '0;
      r_dut_in     <= '0;
      r_exp        <= '0;
      r_cnt        <= '0;
      r_errors     <= '0;
      r_vec_count  <= '0;
      r_first_fail <= '0;
      r_fail_seen  <= 1'b0;
    end else begin
      unique case (r_state)
        ST_IDLE, ST_DONE: begin
          if (bus.i_start) begin
            r_vec_addr   <= '0;
            r_errors     <= '0;
            r_vec_count  <= '0;
            r_first_fail <= '0;
            r_fail_seen  <= 1'b0;
          end
        end
        ST_FETCH: begin
          if (w_valid) begin
            r_dut_in <= w_vin;
            r_exp    <= w_vexp;
            r_cnt    <= SETTLE_LD;
          end
        end
        ST_SETTLE: r_cnt <= r_cnt - 4'd1;
        ST_CHECK: begin
          if (r_vec_count != '1) r_vec_count <= r_vec_count + 16'd1;
          if (w_mismatch) begin
            if (r_errors != '1) r_errors <= r_errors + 16'd1;
            if (!r_fail_seen) begin
              r_first_fail <= r_vec_addr;
              r_fail_seen  <= 1'b1;
            end
          end
          if (w_next == ST_FETCH) r_vec_addr <= r_vec_addr + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.o_vec_addr   = r_vec_addr;
  assign bus.o_dut_in     = r_dut_in;
  assign bus.o_errors     = r_errors;
  assign bus.o_vec_count  = r_vec_count;
  assign bus.o_first_fail = r_first_fail;
  assign bus.o_fail_seen  = r_fail_seen;
endmodule
